decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
Parametrised, registered N-to-M one-hot decoder. It is the sequential successor to the team's combinational 3-to-8 decoder.
- Direct mode: decodes a validated select input.
- Scan mode: an internal dwell counter walks the active output across all M lines, for LED/digit multiplexing and row strobing.
- Sits between control logic and display or strobe drivers.

Parameters:
SEL_W, 3, select width in bits.
NUM_OUT, 8, number of output lines; legal range 2..2**SEL_W.
DWELL, 4, cycles each output stays active in scan mode; minimum 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous assert, active-low.
en  input  1  block enable; 0 forces all outputs low.
mode  input  1  0 = direct, 1 = scan.
sel_in  input  SEL_W  select value used in direct mode.
sel_vld  input  1  qualifies sel_in; sampled only in direct mode.
out  output  NUM_OUT  registered one-hot (or all-zero) decode.
cur_sel  output  SEL_W  index currently decoded (registered).
wrap  output  1  one-cycle pulse when scan wraps NUM_OUT-1 -> 0.
err  output  1  one-cycle pulse when a direct select is out of range.

Behaviour:
- Reset (rst_n=0, async): out=0, cur_sel=0, wrap=0, err=0, dwell counter=0, state=IDLE. Outputs clear immediately, without waiting for a clock edge.
- States: IDLE, DIRECT, SCAN. All transitions occur on the rising edge of clk.
- en=0 from any state: next cycle out=0, state=IDLE, dwell counter=0, cur_sel retained. wrap and err are never asserted in IDLE.
- IDLE, en=1, mode=0: go to DIRECT with out=0. The first sel_vld sets the output.
- IDLE, en=1, mode=1: go to SCAN with cur_sel=0, out=1 (bit 0), dwell counter=0.
- DIRECT, sel_vld=1, sel_in<NUM_OUT: next cycle out=(1<<sel_in), cur_sel=sel_in. Latency is 1 cycle.
- DIRECT, sel_vld=1, sel_in>=NUM_OUT: next cycle out=0 and err=1 for 1 cycle; cur_sel unchanged.
- DIRECT, sel_vld=0: out and cur_sel hold.
- SCAN, dwell counting: the dwell counter counts 0..DWELL-1 while out=(1<<cur_sel).
- SCAN, counter at DWELL-1: counter clears and cur_sel increments. If cur_sel==NUM_OUT-1 it wraps to 0, and wrap=1 in the same cycle that out returns to bit 0.
- SCAN, sel_vld: ignored, never raises err.
- SCAN with DWELL=1: the index advances every cycle.
- Unused select codes (NUM_OUT < 2**SEL_W) are never reached in scan mode.
- DIRECT->SCAN, mode=1 sampled: next cycle cur_sel=0, out=bit 0, dwell counter=0. No wrap pulse.
- SCAN->DIRECT, mode=0 sampled: out and cur_sel freeze at the current value; dwell counter clears. If sel_vld is high in that same cycle, it is decoded normally (latency 1).
- Invariant: out is always either zero or exactly one-hot.
- Reset mid-scan: everything returns to reset values. Scan restarts from bit 0 once rst_n=1 and en=1.

Optional Feature:
DECODER_SCAN_GAP_EN
- Defined, scan mode only: one all-zero "blank" cycle is inserted before each index change (break-before-make for shared drivers).
  - The sequence per index is DWELL active cycles, then 1 blank cycle with out=0. During the blank cycle cur_sel still shows the outgoing index.
  - wrap is asserted in the cycle bit 0 becomes active.
  - One full scan therefore takes NUM_OUT*(DWELL+1) cycles.
  - Direct mode is unaffected.
- Undefined: no blank cycles; a full scan takes NUM_OUT*DWELL cycles.

Test Plan:
- Reset, then direct sweep: rst_n pulse low; en=1, mode=0, apply sel_vld with sel_in=0..7, one per cycle. Each next cycle: out=00000001..10000000, cur_sel tracks sel_in, err=0.
- Out-of-range select: NUM_OUT=6, sel_in=6 with sel_vld -> next cycle out=000000, err=1 for exactly one cycle, cur_sel unchanged.
- Scan timing, default params, en=1, mode=1:
  - out bit 0 is high for 4 cycles, then bit 1, and so on.
  - After 32 cycles out returns to 00000001 with a single wrap pulse.
  - With DECODER_SCAN_GAP_EN defined: 40 cycles per scan, with out=0 on every 5th cycle.
- Mode switch mid-dwell:
  - SCAN at cur_sel=3, dwell=2, set mode=0 -> out holds 00001000.
  - sel_in=5 with sel_vld -> out=00100000.
  - Set mode=1 -> out=00000001, no wrap pulse.
- Disable and async reset: clear en in SCAN -> next cycle out=0, cur_sel retained. Assert rst_n=0 between clock edges -> out, cur_sel, wrap and err are 0 immediately.
- DWELL=1, NUM_OUT=3: out cycles 001, 010, 100, 001, ... with wrap high every 3rd cycle.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered N-to-M one-hot decoder with direct (validated select) and scan (dwell-timed walk) modes.
// Optional macro DECODER_SCAN_GAP_EN inserts one blank cycle before each scan index change.
module decoder_scan #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_vld,
  output logic [NUM_OUT-1:0] out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap,
  output logic               err
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [NUM_OUT-1:0] out_nxt;
  logic [SEL_W-1:0]   cur_sel_nxt;
  logic               wrap_nxt;
  logic               err_nxt;
  logic               sel_ok;
  logic [NUM_OUT-1:0] sel_hot;
  logic [SEL_W-1:0]   sel_adv;
  logic [NUM_OUT-1:0] adv_hot;
`ifdef DECODER_SCAN_GAP_EN
  logic               blank;
  logic               blank_nxt;
`endif

  // Direct-mode decode of the select and the next scan index (with wrap at NUM_OUT-1).
  assign sel_ok  = (32'(sel_in) < NUM_OUT);
  assign sel_hot = NUM_OUT'(1) << sel_in;
  assign sel_adv = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
  assign adv_hot = NUM_OUT'(1) << sel_adv;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = mode ? SCAN : DIRECT;
        DIRECT:  if (mode) state_nxt = SCAN;
        SCAN:    if (!mode) state_nxt = DIRECT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    out_nxt     = out;
    cur_sel_nxt = cur_sel;
    cnt_nxt     = cnt;
    wrap_nxt    = 1'b0;
    err_nxt     = 1'b0;
`ifdef DECODER_SCAN_GAP_EN
    blank_nxt   = 1'b0;
`endif
    if (!en) begin
      out_nxt = '0;
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (mode) begin
            cur_sel_nxt = '0;
            out_nxt     = NUM_OUT'(1);
          end else begin
            out_nxt = '0;
          end
        end
        DIRECT: begin
          cnt_nxt = '0;
          if (mode) begin
            cur_sel_nxt = '0;
            out_nxt     = NUM_OUT'(1);
          end else if (sel_vld) begin
            if (sel_ok) begin
              out_nxt     = sel_hot;
              cur_sel_nxt = sel_in;
            end else begin
              out_nxt = '0;
              err_nxt = 1'b1;
            end
          end
        end
        SCAN: begin
          if (!mode) begin
            // Freeze on exit; a same-cycle valid select still decodes.
            cnt_nxt = '0;
            if (sel_vld) begin
              if (sel_ok) begin
                out_nxt     = sel_hot;
                cur_sel_nxt = sel_in;
              end else begin
                out_nxt = '0;
                err_nxt = 1'b1;
              end
            end
          end
`ifdef DECODER_SCAN_GAP_EN
          else if (blank) begin
            cnt_nxt     = '0;
            cur_sel_nxt = sel_adv;
            out_nxt     = adv_hot;
            wrap_nxt    = (cur_sel == SEL_LAST);
          end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            out_nxt   = '0;
            blank_nxt = 1'b1;
          end
`else
          else if (cnt == CNT_LAST) begin
            cnt_nxt     = '0;
            cur_sel_nxt = sel_adv;
            out_nxt     = adv_hot;
            wrap_nxt    = (cur_sel == SEL_LAST);
          end
`endif
          else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          out_nxt = '0;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      cur_sel <= '0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
`ifdef DECODER_SCAN_GAP_EN
      blank   <= 1'b0;
`endif
    end else begin
      out     <= out_nxt;
      cur_sel <= cur_sel_nxt;
      wrap    <= wrap_nxt;
      err     <= err_nxt;
      cnt     <= cnt_nxt;
`ifdef DECODER_SCAN_GAP_EN
      blank   <= blank_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Randomized bench for decoder_scan: three parameterisations driven in parallel and checked
// against a time-indexed behavioural model.
module tb_decoder_scan;

`ifdef DECODER_SCAN_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  localparam int S_IDLE   = 0;
  localparam int S_DIRECT = 1;
  localparam int S_SCAN   = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel_in;
  logic       sel_vld;

  logic [7:0] o0;
  logic [2:0] cs0;
  logic       w0, e0;
  logic [5:0] o1;
  logic [2:0] cs1;
  logic       w1, e1;
  logic [2:0] o2;
  logic [1:0] cs2;
  logic       w2, e2;

  int total = 0;
  int bad   = 0;

  int nout [3] = '{8, 6, 3};
  int dwl  [3] = '{4, 4, 1};
  int selw [3] = '{3, 3, 2};

  int          st    [3];
  int          tm    [3];
  logic [31:0] m_out [3];
  logic [31:0] m_cur [3];
  logic        m_wrap[3];
  logic        m_err [3];

  decoder_scan #(.SEL_W(3), .NUM_OUT(8), .DWELL(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .sel_vld(sel_vld),
    .out(o0), .cur_sel(cs0), .wrap(w0), .err(e0));
  decoder_scan #(.SEL_W(3), .NUM_OUT(6), .DWELL(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .sel_vld(sel_vld),
    .out(o1), .cur_sel(cs1), .wrap(w1), .err(e1));
  decoder_scan #(.SEL_W(2), .NUM_OUT(3), .DWELL(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in[1:0]), .sel_vld(sel_vld),
    .out(o2), .cur_sel(cs2), .wrap(w2), .err(e2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      st[k] = S_IDLE; tm[k] = 0;
      m_out[k] = '0; m_cur[k] = '0; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  // Scan position is a pure function of cycles since scan entry.
  task automatic model_update(input int k, input logic e, input logic md, input logic v,
                              input logic [2:0] s);
    int sv;
    int per;
    sv  = int'(s) & ((1 << selw[k]) - 1);
    per = dwl[k] + GAP;
    m_wrap[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (!e) begin
      st[k] = S_IDLE;
      m_out[k] = '0;
    end else if (md && st[k] != S_SCAN) begin
      st[k] = S_SCAN; tm[k] = 0; m_cur[k] = 0; m_out[k] = 32'd1;
    end else if (md) begin
      tm[k]++;
      m_cur[k]  = 32'((tm[k] / per) % nout[k]);
      m_out[k]  = ((tm[k] % per) < dwl[k]) ? (32'd1 << m_cur[k]) : 32'd0;
      m_wrap[k] = ((tm[k] % (nout[k] * per)) == 0);
    end else begin
      if (st[k] == S_IDLE) begin
        m_out[k] = '0;
      end else if (v) begin
        if (sv < nout[k]) begin
          m_out[k] = 32'd1 << sv;
          m_cur[k] = 32'(sv);
        end else begin
          m_out[k] = '0;
          m_err[k] = 1'b1;
        end
      end
      st[k] = S_DIRECT;
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] g_out[3];
    logic [31:0] g_cur[3];
    logic        g_wr [3];
    logic        g_er [3];
    g_out[0] = 32'(o0); g_cur[0] = 32'(cs0); g_wr[0] = w0; g_er[0] = e0;
    g_out[1] = 32'(o1); g_cur[1] = 32'(cs1); g_wr[1] = w1; g_er[1] = e1;
    g_out[2] = 32'(o2); g_cur[2] = 32'(cs2); g_wr[2] = w2; g_er[2] = e2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out%0d", ph, k), g_out[k], m_out[k]);
      check($sformatf("%s_cur%0d", ph, k), g_cur[k], m_cur[k]);
      check($sformatf("%s_wrap%0d", ph, k), 32'(g_wr[k]), 32'(m_wrap[k]));
      check($sformatf("%s_err%0d", ph, k), 32'(g_er[k]), 32'(m_err[k]));
      check($sformatf("%s_onehot%0d", ph, k), 32'($onehot0(g_out[k])), 32'd1);
    end
  endtask

  task automatic step(input string ph);
    logic       e, md, v;
    logic [2:0] s;
    e = en; md = mode; v = sel_vld; s = sel_in;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k, e, md, v, s);
    #1;
    check_all(ph);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset(input string ph);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int mid_t;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_in = '0; sel_vld = 1'b0;
    model_reset();
    #12;
    check_all("rst");
    rst_n = 1'b1;

    // Direct sweep over every select code
    en = 1'b1; mode = 1'b0;
    step("enter");
    for (int i = 0; i < 8; i++) begin
      sel_in = 3'(i); sel_vld = 1'b1;
      step("sweep");
      check("sweep_d0", 32'(o0), 32'd1 << i);
    end
    sel_vld = 1'b0;
    step("hold");

    // Full scans
    mode = 1'b1;
    for (int i = 0; i < 2 * 8 * (4 + GAP) + 3; i++) begin
      sel_vld = 1'($urandom); sel_in = 3'($urandom);
      step("scan");
    end

    // Mode switch mid-dwell at index 3, dwell 2
    mode = 1'b0; sel_vld = 1'b0;
    step("exit");
    mode = 1'b1;
    step("reenter");
    mid_t = 3 * (4 + GAP) + 2;
    for (int i = 0; i < mid_t; i++) step("walk");
    mode = 1'b0;
    step("freeze");
    check("mid_hold", 32'(o0), 32'h08);
    sel_in = 3'd5; sel_vld = 1'b1;
    step("mid_sel");
    check("mid_sel5", 32'(o0), 32'h20);
    sel_vld = 1'b0; mode = 1'b1;
    step("mid_back");
    check("mid_bit0", 32'(o0), 32'h01);
    check("mid_nowrap", 32'(w0), 32'd0);

    // Disable in scan, then async reset
    for (int i = 0; i < 6; i++) step("pre_dis");
    en = 1'b0;
    step("dis");
    async_reset("arst");
    en = 1'b1;
    step("restart");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 99) < 4) mode = ~mode;
      sel_vld = 1'($urandom);
      sel_in  = 3'($urandom);
      step("rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
